game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the Pong engine.
- Gates the start menu's up/down controls and latches the selected mode on start.
- Runs the 3-2-1 countdown, issues serve pulses, and keeps score.
- Declares the winner and returns to the menu; sits between the button inputs, the start menu, the ball/paddle logic and the score/text overlays.

---
 rtl/game_flow_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Pong game sequencer: menu gating, 3-2-1 countdown, serves, scoring, game over.
// Define PAUSE_EN to add the PAUSED state driven by btn_pause.
module game_flow_ctrl #(
    parameter int DIGIT_FRAMES       = 60,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int OVER_FRAMES        = 300,
    parameter int WIN_SCORE          = 7,
    parameter int SCORE_W            = 4
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               mode_choice,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic               menu_up,
    output logic               menu_down,
    output logic               show_menu,
    output logic               show_countdown,
    output logic [1:0]         countdown_digit,
    output logic               game_run,
    output logic               serve,
    output logic               serve_dir,
    output logic               mode,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               show_game_over,
    output logic               winner,
    output logic               paused
);
    typedef enum logic [2:0] {
        S_MENU,
        S_COUNTDOWN,
        S_PLAY,
        S_SERVE_WAIT,
        S_GAME_OVER
`ifdef PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    localparam logic [9:0]         CD_LAST = 10'(3*DIGIT_FRAMES - 1);
    localparam logic [9:0]         D1_END  = 10'(DIGIT_FRAMES);
    localparam logic [9:0]         D2_END  = 10'(2*DIGIT_FRAMES);
    localparam logic [9:0]         SW_LAST = 10'(SERVE_DELAY_FRAMES - 1);
    localparam logic [9:0]         GO_LAST = 10'(OVER_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_ST = 2;

`ifdef PAUSE_EN
    localparam int NB   = 4;
    localparam int B_PS = 3;
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_pause, btn_start, btn_down, btn_up};
`else
    localparam int NB = 3;
    logic [NB-1:0] btn_raw;
    logic          unused_pause;
    assign btn_raw      = {btn_start, btn_down, btn_up};
    assign unused_pause = btn_pause;
`endif

    logic [NB-1:0] sync1_q, sync2_q, hist_q, edg;
    state_t        state_q, state_d, view;
    logic [9:0]    cnt_q, cnt_d;
    logic          keep_cnt;
    logic          mode_q, mode_d, winner_q, winner_d, dir_q, dir_d;
    logic          serve_q, serve_d, up_q, up_d, dn_q, dn_d;
    logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
`ifdef PAUSE_EN
    state_t        ret_q, ret_d;
`endif

    assign edg = sync2_q & ~hist_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = frame_tick ? cnt_q + 10'd1 : cnt_q;
        keep_cnt = 1'b0;
        mode_d   = mode_q;
        winner_d = winner_q;
        dir_d    = dir_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        serve_d  = 1'b0;
        up_d     = 1'b0;
        dn_d     = 1'b0;
`ifdef PAUSE_EN
        ret_d    = ret_q;
`endif
        case (state_q)
            S_MENU: begin
                if (edg[B_ST]) begin
                    mode_d  = mode_choice;
                    s1_d    = '0;
                    s2_d    = '0;
                    dir_d   = 1'b1;
                    state_d = S_COUNTDOWN;
                end else if (edg[B_UP]) begin
                    up_d = 1'b1;
                end else if (edg[B_DN]) begin
                    dn_d = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (frame_tick && cnt_q == CD_LAST) begin
                    state_d = S_PLAY;
                    serve_d = 1'b1;
                end
            end
            S_PLAY: begin
                // p1 takes precedence when both players score in the same cycle
                if (point_p1) begin
                    dir_d = 1'b1;
                    s1_d  = (s1_q < WIN) ? s1_q + SCORE_W'(1) : s1_q;
                    if (s1_d == WIN) begin
                        winner_d = 1'b0;
                        state_d  = S_GAME_OVER;
                    end else begin
                        state_d = S_SERVE_WAIT;
                    end
                end else if (point_p2) begin
                    dir_d = 1'b0;
                    s2_d  = (s2_q < WIN) ? s2_q + SCORE_W'(1) : s2_q;
                    if (s2_d == WIN) begin
                        winner_d = 1'b1;
                        state_d  = S_GAME_OVER;
                    end else begin
                        state_d = S_SERVE_WAIT;
                    end
                end
            end
            S_SERVE_WAIT: begin
                if (frame_tick && cnt_q == SW_LAST) begin
                    state_d = S_PLAY;
                    serve_d = 1'b1;
                end
            end
            S_GAME_OVER: begin
                if (edg[B_ST] || (frame_tick && cnt_q == GO_LAST))
                    state_d = S_MENU;
            end
`ifdef PAUSE_EN
            S_PAUSED: begin
                cnt_d = cnt_q;
                if (edg[B_ST]) begin
                    state_d = S_MENU;
                    s1_d    = '0;
                    s2_d    = '0;
                end else if (edg[B_PS]) begin
                    state_d  = ret_q;
                    keep_cnt = 1'b1;
                end
            end
`endif
            default: state_d = S_MENU;
        endcase
`ifdef PAUSE_EN
        // Pause freezes everything, overriding any point or serve decided above
        if (edg[B_PS] && (state_q == S_PLAY || state_q == S_COUNTDOWN ||
                          state_q == S_SERVE_WAIT)) begin
            state_d  = S_PAUSED;
            ret_d    = state_q;
            cnt_d    = cnt_q;
            keep_cnt = 1'b1;
            serve_d  = 1'b0;
            s1_d     = s1_q;
            s2_d     = s2_q;
            dir_d    = dir_q;
            winner_d = winner_q;
        end
`endif
        if (state_d != state_q && !keep_cnt)
            cnt_d = '0;
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            hist_q   <= '0;
            state_q  <= S_MENU;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            winner_q <= 1'b0;
            dir_q    <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            serve_q  <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
`ifdef PAUSE_EN
            ret_q    <= S_MENU;
`endif
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            winner_q <= winner_d;
            dir_q    <= dir_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            serve_q  <= serve_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
`ifdef PAUSE_EN
            ret_q    <= ret_d;
`endif
        end
    end

`ifdef PAUSE_EN
    assign view   = (state_q == S_PAUSED) ? ret_q : state_q;
    assign paused = (state_q == S_PAUSED);
`else
    assign view   = state_q;
    assign paused = 1'b0;
`endif

    assign show_menu       = (view == S_MENU);
    assign show_countdown  = (view == S_COUNTDOWN);
    assign show_game_over  = (view == S_GAME_OVER);
    assign game_run        = (state_q == S_PLAY);
    assign countdown_digit = (view != S_COUNTDOWN || cnt_q < D1_END) ? 2'd3 :
                             (cnt_q < D2_END) ? 2'd2 : 2'd1;
    assign menu_up         = up_q;
    assign menu_down       = dn_q;
    assign serve           = serve_q;
    assign serve_dir       = dir_q;
    assign mode            = mode_q;
    assign winner          = winner_q;
    assign score_p1        = s1_q;
    assign score_p2        = s2_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: scoring table plus hand-written menu/countdown/reset/pause sequences.
module tb_game_flow_ctrl;
    logic       clk_0 = 1'b0, rst = 1'b1, frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
    logic       mode_choice = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0;
    logic       menu_up, menu_down, show_menu, show_countdown, game_run, serve, serve_dir;
    logic       mode, show_game_over, winner, paused;
    logic [1:0] countdown_digit;
    logic [3:0] score_p1, score_p2;

    game_flow_ctrl dut (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start), .btn_pause(btn_pause),
        .mode_choice(mode_choice), .point_p1(point_p1), .point_p2(point_p2),
        .menu_up(menu_up), .menu_down(menu_down), .show_menu(show_menu),
        .show_countdown(show_countdown), .countdown_digit(countdown_digit),
        .game_run(game_run), .serve(serve), .serve_dir(serve_dir), .mode(mode),
        .score_p1(score_p1), .score_p2(score_p2), .show_game_over(show_game_over),
        .winner(winner), .paused(paused)
    );

    always #5 clk_0 = ~clk_0;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int serve_cnt = 0, up_cnt = 0, dn_cnt = 0, last_up_cyc = -1, last_dn_cyc = -1;

    always @(posedge clk_0) cyc <= cyc + 1;

    always @(negedge clk_0) begin
        if (serve) serve_cnt = serve_cnt + 1;
        if (menu_up) begin up_cnt = up_cnt + 1; last_up_cyc = cyc; end
        if (menu_down) begin dn_cnt = dn_cnt + 1; last_dn_cyc = cyc; end
    end

    typedef struct {
        logic p1; logic p2; int s1; int s2; logic dir; logic over;
    } pt_vec_t;
    pt_vec_t vecs[9];

    task automatic step();
        @(posedge clk_0);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_start();
        btn_start = 1'b1; repeat (4) step();
        btn_start = 1'b0; repeat (3) step();
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; repeat (4) step();
        btn_pause = 1'b0; repeat (3) step();
    endtask

    task automatic point(input logic a, input logic b);
        point_p1 = a; point_p2 = b; step();
        point_p1 = 1'b0; point_p2 = 1'b0;
    endtask

    task automatic countdown();
        int s0;
        s0 = serve_cnt;
        for (int t = 0; t < 180; t++) begin
            int e;
            e = (t < 60) ? 3 : (t < 120) ? 2 : 1;
            if (t == 0 || t == 59 || t == 60 || t == 119 || t == 120 || t == 179)
                chk("cd_digit", int'(countdown_digit), e);
            if (t == 179) begin
                chk("cd_no_early_serve", serve_cnt - s0, 0);
                chk("cd_overlay", int'(show_countdown), 1);
            end
            tick();
        end
        chk("cd_serve", serve_cnt - s0, 1);
        chk("cd_run", int'(game_run), 1);
        chk("cd_overlay_off", int'(show_countdown), 0);
    endtask

    task automatic score_and_serve(input logic a, input logic b);
        int s0;
        point(a, b);
        s0 = serve_cnt;
        ticks(60);
        chk("sw_serve", serve_cnt - s0, 1);
    endtask

    initial begin
        int rise, s0;
        vecs[0] = '{1'b0, 1'b1, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1, 1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2, 1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 2, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 3, 2, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 4, 2, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 5, 2, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 6, 2, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 7, 2, 1'b1, 1'b1};

        // reset state
        repeat (2) step();
        chk("rst_menu", int'(show_menu), 1);
        chk("rst_countdown", int'(show_countdown), 0);
        chk("rst_over", int'(show_game_over), 0);
        chk("rst_run", int'(game_run), 0);
        chk("rst_digit", int'(countdown_digit), 3);
        chk("rst_s1", int'(score_p1), 0);
        chk("rst_s2", int'(score_p2), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_dir", int'(serve_dir), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_pulses", int'({serve, menu_up, menu_down, paused}), 0);
        rst = 1'b0;
        step();

        // held down button: one pulse, 3 cycles after the rise
        btn_down = 1'b1; rise = cyc;
        repeat (10) step();
        btn_down = 1'b0; repeat (3) step();
        chk("down_count", dn_cnt, 1);
        chk("down_delay", last_dn_cyc - rise, 3);
        chk("down_no_up", up_cnt, 0);
        btn_up = 1'b1; rise = cyc;
        repeat (6) step();
        btn_up = 1'b0; repeat (3) step();
        chk("up_count", up_cnt, 1);
        chk("up_delay", last_up_cyc - rise, 3);
        // simultaneous up/down: up wins
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (5) step();
        btn_up = 1'b0; btn_down = 1'b0; repeat (3) step();
        chk("both_up", up_cnt, 2);
        chk("both_down", dn_cnt, 1);

        // start together with up: start wins, mode latched
        mode_choice = 1'b1; btn_start = 1'b1; btn_up = 1'b1;
        repeat (4) step();
        btn_start = 1'b0; btn_up = 1'b0; repeat (3) step();
        mode_choice = 1'b0;
        chk("start_no_up", up_cnt, 2);
        chk("start_countdown", int'(show_countdown), 1);
        chk("start_menu_off", int'(show_menu), 0);
        chk("start_mode", int'(mode), 1);
        chk("start_dir", int'(serve_dir), 1);
        btn_down = 1'b1; repeat (5) step(); btn_down = 1'b0; repeat (3) step();
        chk("down_dropped", dn_cnt, 1);
        countdown();
        chk("first_serve_dir", int'(serve_dir), 1);

        // scoring table
        for (int i = 0; i < 9; i++) begin
            point(vecs[i].p1, vecs[i].p2);
            chk("tbl_s1", int'(score_p1), vecs[i].s1);
            chk("tbl_s2", int'(score_p2), vecs[i].s2);
            chk("tbl_dir", int'(serve_dir), int'(vecs[i].dir));
            chk("tbl_run", int'(game_run), 0);
            chk("tbl_over", int'(show_game_over), int'(vecs[i].over));
            if (!vecs[i].over) begin
                s0 = serve_cnt;
                ticks(30);
                point(1'b1, 1'b1);
                ticks(29);
                chk("tbl_no_early_serve", serve_cnt - s0, 0);
                tick();
                chk("tbl_serve", serve_cnt - s0, 1);
                chk("tbl_run_again", int'(game_run), 1);
                chk("tbl_wait_ignores_pts", int'(score_p1) * 16 + int'(score_p2),
                    vecs[i].s1 * 16 + vecs[i].s2);
            end
        end
        chk("go_winner", int'(winner), 0);
        point(1'b0, 1'b1);
        chk("go_ignores_pts", int'(score_p2), 2);
        ticks(299);
        chk("go_hold", int'(show_game_over), 1);
        tick();
        chk("go_timeout_menu", int'(show_menu), 1);
        chk("go_timeout_over_off", int'(show_game_over), 0);
        chk("menu_scores_held", int'(score_p1), 7);
        point(1'b1, 1'b0);
        chk("menu_ignores_pts", int'(score_p1), 7);

        // second game: reset mid serve-wait at 3-2
        mode_choice = 1'b1;
        press_start();
        chk("g2_cleared", int'(score_p1) + int'(score_p2), 0);
        countdown();
        score_and_serve(1'b1, 1'b0);
        score_and_serve(1'b1, 1'b0);
        score_and_serve(1'b0, 1'b1);
        score_and_serve(1'b0, 1'b1);
        point(1'b1, 1'b0);
        chk("g2_s1", int'(score_p1), 3);
        chk("g2_s2", int'(score_p2), 2);
        ticks(30);
        s0 = serve_cnt;
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_menu", int'(show_menu), 1);
        chk("mid_rst_scores", int'(score_p1) + int'(score_p2), 0);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_dir", int'(serve_dir), 0);
        ticks(100);
        chk("mid_rst_no_serve", serve_cnt - s0, 0);
        chk("mid_rst_stays_menu", int'(show_menu), 1);

        // third game: p2 wins, start edge leaves game over early
        mode_choice = 1'b0;
        press_start();
        countdown();
        for (int i = 0; i < 6; i++) score_and_serve(1'b0, 1'b1);
        point(1'b0, 1'b1);
        chk("g3_winner", int'(winner), 1);
        chk("g3_s2", int'(score_p2), 7);
        chk("g3_over", int'(show_game_over), 1);
        chk("g3_dir", int'(serve_dir), 0);
        ticks(100);
        press_start();
        chk("g3_start_menu", int'(show_menu), 1);
        chk("g3_no_restart", int'(show_countdown), 0);
        chk("g3_scores_held", int'(score_p2), 7);

`ifdef PAUSE_EN
        press_start();
        ticks(70);
        chk("p_digit_before", int'(countdown_digit), 2);
        press_pause();
        chk("p_paused", int'(paused), 1);
        chk("p_overlay", int'(show_countdown), 1);
        ticks(100);
        point(1'b1, 1'b0);
        chk("p_digit_held", int'(countdown_digit), 2);
        chk("p_still_paused", int'(paused), 1);
        chk("p_pts_ignored", int'(score_p1), 0);
        s0 = serve_cnt;
        press_pause();
        chk("p_unpaused", int'(paused), 0);
        ticks(109);
        chk("p_no_early_serve", serve_cnt - s0, 0);
        tick();
        chk("p_serve", serve_cnt - s0, 1);
        chk("p_run", int'(game_run), 1);
        point(1'b1, 1'b0);
        press_pause();
        chk("p_sw_paused", int'(paused), 1);
        chk("p_sw_run", int'(game_run), 0);
        press_start();
        chk("p_quit_menu", int'(show_menu), 1);
        chk("p_quit_scores", int'(score_p1), 0);
        chk("p_quit_unpaused", int'(paused), 0);
`else
        press_start();
        ticks(10);
        press_pause();
        chk("np_paused", int'(paused), 0);
        chk("np_digit_runs", int'(show_countdown), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
